// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through data cache controller with one-word lines.
// Read hits return data in the same cycle; read misses and stores stall until the backing memory acks.
module dcache_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    input  logic          flush,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = AW - IDX_W;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DW-1:0]      data_mem [LINES];

    logic               line_we;
    logic [DW-1:0]      line_wdata;

    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [IDX_W-1:0]   cap_idx;
    logic [TAG_W-1:0]   cap_tag;
    logic               cpu_hit;
    logic               cap_hit;

    assign cpu_idx = cpu_addr[IDX_W-1:0];
    assign cpu_tag = cpu_addr[AW-1:IDX_W];
    assign cap_idx = mem_addr_q[IDX_W-1:0];
    assign cap_tag = mem_addr_q[AW-1:IDX_W];

    // Lookup for the incoming request, and for the captured address at the end of a store.
    assign cpu_hit = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign cap_hit = valid_q[cap_idx] && (tag_mem[cap_idx] == cap_tag);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we     = 1'b0;
        line_wdata  = mem_rdata;
        stall       = 1'b0;
        cpu_rdata   = '0;

        unique case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    state_d     = WR_THRU;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    stall       = 1'b1;
                end else if (cpu_re) begin
                    if (cpu_hit) begin
                        cpu_rdata = data_mem[cpu_idx];
                        if (hit_cnt_q != CNT_MAX) begin
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d    = RD_MISS;
                        mem_addr_d = cpu_addr;
                        stall      = 1'b1;
                        if (miss_cnt_q != CNT_MAX) begin
                            miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        end
                    end
                end else if (flush) begin
                    valid_d = '0;
                end
            end

            // Fill completes on the ack edge; the ack cycle itself bypasses mem_rdata.
            RD_MISS: begin
                stall = ~mem_ack;
                if (mem_ack) begin
                    cpu_rdata        = mem_rdata;
                    state_d          = IDLE;
                    valid_d[cap_idx] = 1'b1;
                    line_we          = 1'b1;
                    line_wdata       = mem_rdata;
                end
            end

            // Write-through without allocation: only a resident line is refreshed.
            WR_THRU: begin
                stall = ~mem_ack;
                if (mem_ack) begin
                    state_d = IDLE;
                    if (cap_hit) begin
                        line_we    = 1'b1;
                        line_wdata = mem_wdata_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[cap_idx]  <= cap_tag;
            data_mem[cap_idx] <= line_wdata;
        end
    end

    assign mem_req   = (state_q != IDLE);
    assign mem_we    = (state_q == WR_THRU);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through data cache between the pipeline's memory-access stage and the data-memory array. Serves read hits in the same cycle; stalls the pipeline on read misses and on all stores. Misses and stores go to backing memory over a req/ack handshake. Also keeps saturating hit and miss counters for performance measurement.

## Interface

Parameters:
- LINES, 16: number of one-word lines; power of two, 2..256; IDX_W = log2(LINES).
- AW, 16: address width in words.
- DW, 16: data width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- cpu_re  in  1  load request; held stable while stall=1.
- cpu_we  in  1  store request; wins if asserted together with cpu_re.
- cpu_addr  in  AW  word address; held stable while stall=1.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data; valid when cpu_re=1 and stall=0.
- stall  out  1  freezes all pipeline registers up to and including EX/ME.
- flush  in  1  invalidates all lines; accepted only in IDLE with no request pending.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  backing-memory address.
- mem_wdata  out  DW  backing-memory write data.
- mem_ack  in  1  one-cycle completion strobe; ignored while mem_req=0.
- mem_rdata  in  DW  read data; valid in the mem_ack cycle.
- hit_cnt  out  16  read-hit count, saturating.
- miss_cnt  out  16  read-miss count, saturating.

## Operation

- Address split: index = cpu_addr[IDX_W-1:0]; tag = cpu_addr[AW-1:IDX_W]. Each line holds a valid bit, a tag and DW bits of data.
- hit = valid[index] & (tag_mem[index] == tag), evaluated combinationally.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - cpu_we=1: go to WR_THRU. Capture addr and wdata into the mem_* registers. stall=1.
  - else cpu_re=1 and hit: cpu_rdata = line data, stall=0, hit_cnt increments.
  - else cpu_re=1 and miss: go to RD_MISS. Capture addr, mem_we=0. stall=1. miss_cnt increments (once per miss).
  - else flush=1: clear all valid bits at the edge.
- RD_MISS:
  - stall=1 until mem_ack.
  - Ack cycle: stall=0 and cpu_rdata = mem_rdata (bypass).
  - At the ack edge: write the line (valid=1, tag, data) and return to IDLE.
- WR_THRU:
  - stall=1 until mem_ack; in the ack cycle stall=0.
  - At the ack edge: if the line hit, update its data word; on a miss, no allocation. Return to IDLE.
- mem_req = (state != IDLE). mem_we = (state == WR_THRU). mem_addr and mem_wdata come from the capture registers and stay stable for the whole request.
- Counters saturate at 16'hFFFF and do not wrap. They are cleared only by rst.
- flush arriving outside IDLE, or together with a request, is ignored (not queued).

## Timing

- Reset values:
  - state=IDLE; all valid bits 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - stall=0 with no request present; cpu_rdata=0.
  - hit_cnt=0, miss_cnt=0.
  - Tag and data arrays are not reset.
- rst asserted mid-transaction drops mem_req immediately, abandons the transaction and does not fill the line. Backing memory must tolerate a dropped request.
- Read hit: 0 added cycles.
- Read miss: detect in cycle N, mem_req high from N+1, data returned in the ack cycle. With a zero-wait ack in N+1, the miss costs exactly 1 stall cycle.
- Store: same timing as a read miss; minimum 1 stall cycle per store.
- mem_ack in the same cycle that mem_req first rises is legal.
- A load to the same address immediately after a fill hits, with 0 stall.
- A store to a line that is currently cached is visible to the next load, which hits with the new data.
- Single outstanding transaction only; no requests are accepted while stall=1.

## Test plan

- Cold read: after reset, cpu_re to addr 0x0025 with memory returning 0xBEEF and ack one cycle after req → stall high for 2 cycles, cpu_rdata=0xBEEF in the ack cycle, miss_cnt=1. Repeat read → stall=0, rdata=0xBEEF, hit_cnt=1.
- Conflict: read 0x0025, then 0x0035 (same index 5, LINES=16), then 0x0025 again → three misses; mem_addr matches each address.
- Store hit: cached 0x0025, store 0x1234 → mem_req with mem_we=1, mem_addr=0x0025, mem_wdata=0x1234. After ack, a read hits and returns 0x1234. A store to an uncached address does not allocate: the next read misses.
- Zero-wait ack: mem_ack tied high → every miss or store gives exactly 1 stall cycle, and mem_req pulses for 1 cycle.
- Flush and reset: fill 4 lines, assert flush in IDLE → next reads all miss. Assert rst while mem_req is high → mem_req=0 asynchronously, no line filled, counters=0.
- Saturation: force 65 540 hits → hit_cnt holds at 0xFFFF.
